// File: rtl/wave_capture_buffer_pkg.sv
// rtl/wave_capture_buffer_pkg.sv - shared state encoding, frame constants and header byte mux
package wave_capture_buffer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CAPTURE   = 3'd1,
        ST_SEND_HDR  = 3'd2,
        ST_SEND_DATA = 3'd3,
        ST_DONE      = 3'd4
    } state_t;

    localparam logic [7:0] SYNC0_DEF = 8'hA5;
    localparam logic [7:0] SYNC1_DEF = 8'h5A;
    localparam int         HDR_BYTES = 6;

    // Header order: sync0, sync1, wavenum hi/lo, count hi/lo.
    function automatic logic [7:0] hdr_byte(input logic [2:0]  idx,
                                            input logic [7:0]  s0,
                                            input logic [7:0]  s1,
                                            input logic [15:0] wn,
                                            input logic [15:0] cnt);
        case (idx)
            3'd0:    hdr_byte = s0;
            3'd1:    hdr_byte = s1;
            3'd2:    hdr_byte = wn[15:8];
            3'd3:    hdr_byte = wn[7:0];
            3'd4:    hdr_byte = cnt[15:8];
            default: hdr_byte = cnt[7:0];
        endcase
    endfunction

endpackage

// File: rtl/wave_capture_buffer_if.sv
// rtl/wave_capture_buffer_if.sv - acquisition, UART byte stream and status signals of the capture buffer
interface wave_capture_buffer_if #(
    parameter int ADC_W = 12
) ();
    logic             acquire;
    logic [ADC_W-1:0] adc_data;
    logic             adc_valid;
    logic [7:0]       tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic [15:0]      wavenum;
    logic             busy;
    logic             overflow;

    modport master (
        input  acquire, adc_data, adc_valid, tx_ready,
        output tx_data, tx_valid, wavenum, busy, overflow
    );

    modport slave (
        output acquire, adc_data, adc_valid, tx_ready,
        input  tx_data, tx_valid, wavenum, busy, overflow
    );
endinterface

// File: rtl/wave_ram.sv
// rtl/wave_ram.sv - simple dual-port sample RAM with registered read, block-RAM inferable
module wave_ram #(
    parameter int DATA_W = 12,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end
endmodule

// File: rtl/wave_capture_buffer.sv
// rtl/wave_capture_buffer.sv - captures ADC samples during the window and streams a framed record to the UART
module wave_capture_buffer
    import wave_capture_buffer_pkg::*;
#(
    parameter int         ADC_W  = 12,
    parameter int         DEPTH  = 1024,
    parameter int         ADDR_W = $clog2(DEPTH),
    parameter logic [7:0] SYNC0  = SYNC0_DEF,
    parameter logic [7:0] SYNC1  = SYNC1_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    wave_capture_buffer_if.master bus
);

    state_t            state;
    logic [ADDR_W:0]   wr_cnt;
    logic [ADDR_W:0]   rd_idx;
    logic [2:0]        hdr_idx;
    logic              next_is_lsb;
    logic [7:0]        lsb_q;
    logic [15:0]       wavenum_q;
    logic [7:0]        tx_data_q;
    logic              tx_valid_q;
    logic              busy_q;
    logic              overflow_q;

    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [ADC_W-1:0]  ram_rdata;
    logic [ADDR_W:0]   cnt_after;
    logic              depth_hit;
    logic [15:0]       samp16;
    logic [15:0]       count16;
    logic              tx_fire;

    wave_ram #(
        .DATA_W (ADC_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (bus.adc_data),
        .raddr (rd_idx[ADDR_W-1:0]),
        .rdata (ram_rdata)
    );

    // The first sample may arrive on the same cycle the window opens in IDLE.
    always_comb begin
        ram_we    = bus.adc_valid &&
                    ((state == ST_CAPTURE) || ((state == ST_IDLE) && !bus.acquire));
        ram_waddr = (state == ST_IDLE) ? '0 : wr_cnt[ADDR_W-1:0];
        cnt_after = wr_cnt + {{ADDR_W{1'b0}}, ram_we};
        depth_hit = (cnt_after == (ADDR_W+1)'(DEPTH));
        samp16    = '0;
        samp16[ADC_W-1:0] = ram_rdata;
        count16   = 16'(wr_cnt);
        tx_fire   = tx_valid_q && bus.tx_ready;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            wr_cnt      <= '0;
            rd_idx      <= '0;
            hdr_idx     <= '0;
            next_is_lsb <= 1'b0;
            lsb_q       <= '0;
            wavenum_q   <= 16'h0001;
            tx_data_q   <= '0;
            tx_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!bus.acquire) begin
                        state      <= ST_CAPTURE;
                        busy_q     <= 1'b1;
                        overflow_q <= 1'b0;
                        wr_cnt     <= {{ADDR_W{1'b0}}, ram_we};
                    end
                end

                ST_CAPTURE: begin
                    wr_cnt <= cnt_after;
                    // rd_idx is parked at 0 so sample 0 is already in rdata when the header ends.
                    if (bus.acquire || depth_hit) begin
                        state      <= ST_SEND_HDR;
                        tx_valid_q <= 1'b1;
                        tx_data_q  <= SYNC0;
                        hdr_idx    <= 3'd1;
                        rd_idx     <= '0;
                        if (depth_hit) begin
                            overflow_q <= 1'b1;
                        end
                    end
                end

                ST_SEND_HDR: begin
                    if (!bus.acquire) begin
                        overflow_q <= 1'b1;
                    end
                    if (tx_fire) begin
                        if (hdr_idx == 3'(HDR_BYTES)) begin
                            if (wr_cnt == '0) begin
                                state      <= ST_DONE;
                                tx_valid_q <= 1'b0;
                            end else begin
                                state       <= ST_SEND_DATA;
                                tx_data_q   <= samp16[15:8];
                                lsb_q       <= samp16[7:0];
                                rd_idx      <= rd_idx + 1'b1;
                                next_is_lsb <= 1'b1;
                            end
                        end else begin
                            tx_data_q <= hdr_byte(hdr_idx, SYNC0, SYNC1, wavenum_q, count16);
                            hdr_idx   <= hdr_idx + 3'd1;
                        end
                    end
                end

                ST_SEND_DATA: begin
                    if (!bus.acquire) begin
                        overflow_q <= 1'b1;
                    end
                    // Advancing rd_idx on the MSB byte gives the RAM a cycle to prefetch the next sample.
                    if (tx_fire) begin
                        if (next_is_lsb) begin
                            tx_data_q   <= lsb_q;
                            next_is_lsb <= 1'b0;
                        end else if (rd_idx == wr_cnt) begin
                            state      <= ST_DONE;
                            tx_valid_q <= 1'b0;
                        end else begin
                            tx_data_q   <= samp16[15:8];
                            lsb_q       <= samp16[7:0];
                            rd_idx      <= rd_idx + 1'b1;
                            next_is_lsb <= 1'b1;
                        end
                    end
                end

                ST_DONE: begin
                    if (!bus.acquire) begin
                        overflow_q <= 1'b1;
                    end
                    wavenum_q <= wavenum_q + 16'd1;
                    state     <= ST_IDLE;
                    busy_q    <= 1'b0;
                end

                default: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.tx_data  = tx_data_q;
    assign bus.tx_valid = tx_valid_q;
    assign bus.wavenum  = wavenum_q;
    assign bus.busy     = busy_q;
    assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_wave_capture_buffer.sv
// tb/tb_wave_capture_buffer.sv - randomized record capture/stream bench against a frame-level model
module tb_wave_capture_buffer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wave_capture_buffer_if #(.ADC_W(12)) bus ();

    wave_capture_buffer #(.ADC_W(12), .DEPTH(1024)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int         checks = 0;
    int         errors = 0;
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];
    logic [11:0] win[$];
    logic [15:0] wn_model;
    logic       exp_ovf;
    int         ready_pct = 100;
    logic       stalled = 1'b0;
    logic [7:0] stall_data = 8'h00;

    always @(posedge clk) begin
        #1;
        bus.tx_ready = ($urandom_range(0, 99) < ready_pct);
    end

    // Byte collector plus hold-stable check on stalled transfers.
    always @(negedge clk) begin
        if (rst !== 1'b0) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                checks++;
                assert (bus.tx_valid === 1'b1 && bus.tx_data === stall_data) else begin
                    errors++;
                    $error("FAIL tx_hold obs=%b/%h exp=1/%h", bus.tx_valid, bus.tx_data, stall_data);
                end
            end
            if (bus.tx_valid === 1'b1 && bus.tx_ready === 1'b1) rx_q.push_back(bus.tx_data);
            stalled    = (bus.tx_valid === 1'b1) && (bus.tx_ready !== 1'b1);
            stall_data = bus.tx_data;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    // Drives one acquisition window and appends the expected frame to exp_q.
    task automatic do_window(input int n_cyc, input int stride, input bit coinc);
        int k = 0;
        int n;
        for (int c = 0; c < n_cyc; c++) begin
            @(posedge clk); #1;
            bus.acquire = 1'b0;
            if ((c % stride) == 0 && k < win.size()) begin
                bus.adc_valid = 1'b1;
                bus.adc_data  = win[k];
                k++;
            end else begin
                bus.adc_valid = 1'b0;
            end
        end
        @(posedge clk); #1;
        bus.acquire   = 1'b1;
        bus.adc_valid = 1'b0;
        if (coinc && k < win.size()) begin
            bus.adc_valid = 1'b1;
            bus.adc_data  = win[k];
            k++;
        end
        @(posedge clk); #1;
        bus.adc_valid = 1'b0;
        n = (k > 1024) ? 1024 : k;
        exp_ovf = (k >= 1024);
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h5A);
        exp_q.push_back(wn_model[15:8]);
        exp_q.push_back(wn_model[7:0]);
        exp_q.push_back(8'(n >> 8));
        exp_q.push_back(8'(n));
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({4'h0, win[i][11:8]});
            exp_q.push_back(win[i][7:0]);
        end
    endtask

    task automatic wait_bytes(input string tag, input int nbytes, input int budget);
        int t = 0;
        while (rx_q.size() < nbytes && t < budget) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_bytes_timeout"}, 32'(t < budget), 32'd1);
    endtask

    task automatic finish_record(input string tag, input int budget);
        int t = 0;
        int n;
        @(negedge clk);
        while (bus.busy !== 1'b0 && t < budget) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_idle_timeout"}, 32'(t < budget), 32'd1);
        chk({tag, "_nbytes"}, rx_q.size(), exp_q.size());
        n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_b%0d", tag, i), 32'(rx_q[i]), 32'(exp_q[i]));
        end
        wn_model = wn_model + 16'd1;
        chk({tag, "_wavenum"}, 32'(bus.wavenum), 32'(wn_model));
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_overflow"}, 32'(bus.overflow), 32'(exp_ovf));
        rx_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int n;
        int stride;
        rst           = 1'b1;
        bus.acquire   = 1'b1;
        bus.adc_valid = 1'b0;
        bus.adc_data  = '0;
        bus.tx_ready  = 1'b1;
        wn_model      = 16'h0001;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tx_data", 32'(bus.tx_data), 32'h0);
        chk("rst_tx_valid", 32'(bus.tx_valid), 32'h0);
        chk("rst_wavenum", 32'(bus.wavenum), 32'h0001);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_overflow", 32'(bus.overflow), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Three samples spread over a five cycle window.
        win = '{12'h123, 12'h456, 12'hFFF};
        do_window(5, 2, 1'b0);
        finish_record("t1", 200);

        win.delete();
        do_window(3, 1, 1'b0);
        finish_record("t2_empty", 200);

        win.delete();
        for (int i = 0; i < 1100; i++) win.push_back(12'($urandom));
        do_window(1100, 1, 1'b0);
        finish_record("t3_full", 6000);

        ready_pct = 30;
        win = '{12'h123, 12'h456, 12'hFFF};
        do_window(5, 2, 1'b0);
        finish_record("t4_stall", 1000);

        for (int r = 0; r < 6; r++) begin
            ready_pct = $urandom_range(20, 100);
            n         = $urandom_range(0, 24);
            stride    = $urandom_range(1, 3);
            win.delete();
            for (int i = 0; i <= n; i++) win.push_back(12'($urandom));
            do_window((n * stride) + 1, stride, 1'($urandom_range(0, 1)));
            finish_record($sformatf("rnd%0d", r), 3000);
        end

        // Window reopens briefly while the record is still being sent.
        ready_pct = 100;
        win = '{12'h0AB, 12'h7CD, 12'h00E};
        do_window(3, 1, 1'b0);
        wait_bytes("t7", 8, 200);
        @(posedge clk); #1;
        bus.acquire = 1'b0;
        @(posedge clk); #1;
        bus.acquire = 1'b1;
        exp_ovf = 1'b1;
        finish_record("t7_reopen", 200);

        // Reset in the middle of the sample bytes.
        win = '{12'h111, 12'h222, 12'h333, 12'h444};
        do_window(4, 1, 1'b0);
        wait_bytes("t5", 8, 200);
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        chk("t5_rst_tx_valid", 32'(bus.tx_valid), 32'h0);
        chk("t5_rst_wavenum", 32'(bus.wavenum), 32'h0001);
        chk("t5_rst_busy", 32'(bus.busy), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        rx_q.delete();
        exp_q.delete();
        wn_model = 16'h0001;
        win = '{12'h5A5, 12'h0C3};
        do_window(2, 1, 1'b0);
        finish_record("t5_after", 200);

        // Jump wavenum to the top of its range to see the wrap.
        @(negedge clk);
        force dut.wavenum_q = 16'hFFFF;
        @(posedge clk); #1;
        release dut.wavenum_q;
        wn_model = 16'hFFFF;
        win = '{12'h321, 12'h654};
        do_window(2, 1, 1'b0);
        finish_record("t6_wrap", 200);
        win.delete();
        do_window(1, 1, 1'b0);
        finish_record("t6_post", 200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
